// File: rtl/mult_share_arb.sv
// mult_share_arb: one unsigned WIDTH x WIDTH multiplier shared by NREQ requesters.
// A round-robin arbiter grants one requester at a time, latches its operands,
// computes the product in a registered stage and returns it on a valid/ready port.
module mult_share_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 3,
   parameter int IDW   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   multiplicand_flat,
   input  logic [NREQ*WIDTH-1:0]   multiplier_flat,
   output logic [NREQ-1:0]         gnt,
   output logic                    rsp_valid,
   output logic [IDW-1:0]          rsp_id,
   output logic [2*WIDTH-1:0]      rsp_product,
   input  logic                    rsp_ready,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]       rsp_id_q, rsp_id_d;
   logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [IDW-1:0]       last_q, last_d;

   logic                 sel_found;
   logic [IDW-1:0]       sel_idx;
   logic [WIDTH-1:0]     sel_a;
   logic [WIDTH-1:0]     sel_b;
   logic [NREQ-1:0]      sel_onehot;

   // Round-robin pick: first asserted request scanning last+1, last+2, ... modulo NREQ.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!sel_found && req[(int'(last_q) + k) % NREQ]) begin
            sel_found = 1'b1;
            sel_idx   = IDW'((int'(last_q) + k) % NREQ);
         end
      end
   end

   // Operand slices and one-hot grant vector belonging to the selected requester.
   always_comb begin
      sel_a      = '0;
      sel_b      = '0;
      sel_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel_idx == IDW'(i)) begin
            sel_a         = multiplicand_flat[i*WIDTH +: WIDTH];
            sel_b         = multiplier_flat[i*WIDTH +: WIDTH];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // Next-state and register-input logic; every register holds its value unless a state acts on it.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_product_d = rsp_product_q;
      a_d           = a_q;
      b_d           = b_q;
      last_d        = last_q;
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               gnt_d    = sel_onehot;
               a_d      = sel_a;
               b_d      = sel_b;
               rsp_id_d = sel_idx;
               last_d   = sel_idx;
               state_d  = MULT;
            end
         end
         MULT: begin
            rsp_product_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
            rsp_valid_d   = 1'b1;
            gnt_d         = '0;
            state_d       = RESP;
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset discards any in-flight operation and gives requester 0 top priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         gnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_product_q <= '0;
         a_q           <= '0;
         b_q           <= '0;
         last_q        <= IDW'(NREQ - 1);
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_product_q <= rsp_product_d;
         a_q           <= a_d;
         b_q           <= b_d;
         last_q        <= last_d;
      end
   end

   assign gnt         = gnt_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_product = rsp_product_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arb.sv
// Testbench for mult_share_arb: directed scenarios plus a randomized phase,
// checked by a scoreboard fed from a transaction-level round-robin model.
module tb_mult_share_arb;

   localparam int NREQ  = 4;
   localparam int WIDTH = 3;
   localparam int IDW   = 2;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NREQ-1:0]        req;
   logic [NREQ*WIDTH-1:0]  multiplicand_flat;
   logic [NREQ*WIDTH-1:0]  multiplier_flat;
   logic [NREQ-1:0]        gnt;
   logic                   rsp_valid;
   logic [IDW-1:0]         rsp_id;
   logic [2*WIDTH-1:0]     rsp_product;
   logic                   rsp_ready;
   logic                   busy;

   mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req               (req),
      .multiplicand_flat (multiplicand_flat),
      .multiplier_flat   (multiplier_flat),
      .gnt               (gnt),
      .rsp_valid         (rsp_valid),
      .rsp_id            (rsp_id),
      .rsp_product       (rsp_product),
      .rsp_ready         (rsp_ready),
      .busy              (busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int product;
      int grantCycle;
      bit seen;
   } exp_t;

   exp_t sbQueue[$];
   int   total = 0;
   int   bad = 0;
   int   cycle = 0;

   bit   pendValid[NREQ];
   int   pendA[NREQ];
   int   pendB[NREQ];
   int   lastPtr = NREQ - 1;
   int   readyPct = 100;
   bit   autoFill = 1'b0;
   int   hsCycle = -10;
   bit   hsPending = 1'b0;
   int   lastGrantCycle = 0;

   // Cycle counter used to time grants and responses.
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   function automatic bit anyPending();
      for (int i = 0; i < NREQ; i++) if (pendValid[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Round-robin choice among the requesters the bench currently has waiting.
   function automatic int pickNext();
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (lastPtr + k) % NREQ;
         if (pendValid[c]) return c;
      end
      return -1;
   endfunction

   task automatic applyStimulus(input int id, input int a, input int b);
      pendValid[id] = 1'b1;
      pendA[id]     = a;
      pendB[id]     = b;
   endtask

   task automatic clearModel();
      for (int i = 0; i < NREQ; i++) pendValid[i] = 1'b0;
      sbQueue.delete();
      lastPtr        = NREQ - 1;
      hsPending      = 1'b0;
      hsCycle        = -10;
      lastGrantCycle = cycle;
   endtask

   // One cycle of driving: check any grant against the model, then refresh the inputs.
   task automatic stepCycle();
      int expId;
      @(negedge clk);
      if (rst_n) begin
         if (gnt != '0) begin
            expId = pickNext();
            checkOutput("gnt_while_busy", sbQueue.size(), 0);
            checkOutput("gnt", int'(gnt), (expId >= 0) ? (1 << expId) : 0);
            if (expId >= 0) begin
               sbQueue.push_back('{expId, pendA[expId] * pendB[expId], cycle, 1'b0});
               pendValid[expId] = 1'b0;
               lastPtr          = expId;
            end
            lastGrantCycle = cycle;
         end else if (hsPending && cycle == hsCycle + 2) begin
            expId = pickNext();
            checkOutput("gnt_after_handshake", int'(gnt), (expId >= 0) ? (1 << expId) : 0);
            hsPending = 1'b0;
         end else if (anyPending() && (cycle - lastGrantCycle) > 60) begin
            total++;
            bad++;
            $display("[TB] FAIL grant_timeout actual=none required=grant (cycle %0d)", cycle);
            lastGrantCycle = cycle;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!pendValid[i] && autoFill && ($urandom_range(2) == 0))
            applyStimulus(i, int'($urandom_range(7)), int'($urandom_range(7)));
      end
      for (int i = 0; i < NREQ; i++) begin
         req[i] = pendValid[i];
         multiplicand_flat[i*WIDTH +: WIDTH] = pendValid[i] ? WIDTH'(pendA[i]) : WIDTH'($urandom_range(7));
         multiplier_flat[i*WIDTH +: WIDTH]   = pendValid[i] ? WIDTH'(pendB[i]) : WIDTH'($urandom_range(7));
      end
      rsp_ready = ($urandom_range(99) < readyPct);
   endtask

   task automatic waitDrain(input int limit);
      int n;
      n = 0;
      while ((anyPending() || sbQueue.size() != 0) && n < limit) begin
         stepCycle();
         n++;
      end
      if (n >= limit) begin
         total++;
         bad++;
         $display("[TB] FAIL drain_timeout actual=%0d queued required=0", sbQueue.size());
      end
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      clearModel();
      stepCycle();
      rst_n = 1'b1;
      lastGrantCycle = cycle;
   endtask

   // Monitor: whenever a response is presented, compare it with the oldest expected one.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && rsp_valid) begin
         if (sbQueue.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_rsp actual=id%0d/%0d required=none", rsp_id, rsp_product);
         end else begin
            checkOutput("rsp_id", int'(rsp_id), sbQueue[0].id);
            checkOutput("rsp_product", int'(rsp_product), sbQueue[0].product);
            if (!sbQueue[0].seen) begin
               checkOutput("rsp_latency", cycle - sbQueue[0].grantCycle, 1);
               sbQueue[0].seen = 1'b1;
            end
            if (rsp_ready) begin
               void'(sbQueue.pop_front());
               hsCycle   = cycle;
               hsPending = anyPending();
            end
         end
      end
   end

   initial begin
      int n;
      rst_n             = 1'b0;
      req               = '0;
      multiplicand_flat = '0;
      multiplier_flat   = '0;
      rsp_ready         = 1'b0;
      clearModel();
      #1;
      checkOutput("reset_gnt", int'(gnt), 0);
      checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
      checkOutput("reset_rsp_id", int'(rsp_id), 0);
      checkOutput("reset_rsp_product", int'(rsp_product), 0);
      checkOutput("reset_busy", int'(busy), 0);
      stepCycle();
      rst_n = 1'b1;

      $display("[TB] single requester");
      readyPct = 100;
      applyStimulus(0, 5, 7);
      waitDrain(20);
      stepCycle();
      checkOutput("busy_after_handshake", int'(busy), 0);

      $display("[TB] simultaneous requesters 0 and 2");
      resetDut();
      applyStimulus(0, 3, 4);
      applyStimulus(2, 6, 2);
      waitDrain(30);

      $display("[TB] all four requesters");
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NREQ; i++) applyStimulus(i, i + 2 + r, 7 - i - r);
         waitDrain(60);
      end

      $display("[TB] backpressure");
      readyPct = 0;
      applyStimulus((lastPtr + 1) % NREQ, 7, 7);
      for (int i = 0; i < NREQ; i++) if (!pendValid[i]) applyStimulus(i, i + 1, 3);
      n = 0;
      while (!rsp_valid && n < 10) begin
         stepCycle();
         n++;
      end
      checkOutput("bp_rsp_valid_seen", int'(rsp_valid), 1);
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkOutput("bp_gnt_quiet", int'(gnt), 0);
      end
      readyPct = 100;
      waitDrain(60);

      $display("[TB] operand boundaries");
      applyStimulus(1, 0, 6);
      applyStimulus(2, 7, 1);
      applyStimulus(3, 7, 7);
      waitDrain(40);

      $display("[TB] reset during response");
      readyPct = 0;
      applyStimulus(0, 5, 5);
      n = 0;
      while (!rsp_valid && n < 20) begin
         stepCycle();
         n++;
      end
      checkOutput("rst_pre_rsp_valid", int'(rsp_valid), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_gnt", int'(gnt), 0);
      checkOutput("rst_mid_rsp_valid", int'(rsp_valid), 0);
      checkOutput("rst_mid_rsp_id", int'(rsp_id), 0);
      checkOutput("rst_mid_rsp_product", int'(rsp_product), 0);
      checkOutput("rst_mid_busy", int'(busy), 0);
      clearModel();
      readyPct = 100;
      applyStimulus(1, 3, 5);
      applyStimulus(3, 2, 6);
      stepCycle();
      rst_n = 1'b1;
      lastGrantCycle = cycle;
      waitDrain(40);

      $display("[TB] randomized traffic");
      resetDut();
      readyPct = 75;
      autoFill = 1'b1;
      for (int i = 0; i < 400; i++) stepCycle();
      autoFill = 1'b0;
      readyPct = 100;
      waitDrain(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
